// File: rtl/euler_pkg.sv
// Shared types and constants for the Fibonacci-family accumulator.
package euler_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_ALL  = 2'd0;
    localparam mode_t MODE_EVEN = 2'd1;
    localparam mode_t MODE_ODD  = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/fib_sum_engine_if.sv
// Request/response bundle of fib_sum_engine; the controller holds the master side.
interface fib_sum_engine_if
    import euler_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) ();

    logic             start;
    mode_t            mode;
    logic [WIDTH-1:0] limit;
    logic [WIDTH-1:0] seed0;
    logic [WIDTH-1:0] seed1;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [CNT_W-1:0] count;
    logic             overflow;

    modport master (
        output start, mode, limit, seed0, seed1,
        input  busy, done, result, count, overflow
    );

    modport slave (
        input  start, mode, limit, seed0, seed1,
        output busy, done, result, count, overflow
    );

endinterface

// File: rtl/fib_acc_step.sv
// Combinational filter/accumulate step: does term b qualify, and what would the sum become.
module fib_acc_step
    import euler_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_b,
    input  logic [WIDTH-1:0] i_result,
    input  mode_t            i_mode,
    output logic             o_match,
    output logic [WIDTH-1:0] o_new_sum,
    output logic             o_carry
);

    logic [WIDTH:0] w_sum;

    assign w_sum     = {1'b0, i_result} + {1'b0, i_b};
    assign o_new_sum = w_sum[WIDTH-1:0];
    assign o_carry   = w_sum[WIDTH];

    always_comb begin
        o_match = 1'b1;
        case (i_mode)
            MODE_ALL:  o_match = 1'b1;
            MODE_EVEN: o_match = ~i_b[0];
            MODE_ODD:  o_match = i_b[0];
            default:   o_match = 1'b1;   // reserved code behaves as ALL
        endcase
    end

endmodule

// File: rtl/fib_sum_engine.sv
// Fibonacci-family accumulator: walks a, b from run-time seeds, summing filtered terms up to a limit.
//
// state | meaning
// IDLE  | after reset, waiting for start
// RUN   | one term examined per clock
// DONE  | results held, waiting for next start
module fib_sum_engine
    import euler_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    fib_sum_engine_if.slave   bus
);

    state_t           r_state,     w_state_nxt;
    logic [WIDTH-1:0] r_a,         w_a_nxt;
    logic [WIDTH-1:0] r_b,         w_b_nxt;
    logic             r_term_carry, w_term_carry_nxt;
    logic [WIDTH-1:0] r_limit,     w_limit_nxt;
    mode_t            r_mode,      w_mode_nxt;
    logic [WIDTH-1:0] r_result,    w_result_nxt;
    logic [CNT_W-1:0] r_count,     w_count_nxt;
    logic             r_overflow,  w_overflow_nxt;
    logic             r_busy,      w_busy_nxt;
    logic             r_done,      w_done_nxt;

    logic             w_match;
    logic             w_sum_carry;
    logic [WIDTH-1:0] w_new_sum;
    logic [WIDTH:0]   w_next_term;

    fib_acc_step #(.WIDTH(WIDTH)) u_acc_step (
        .i_b       (r_b),
        .i_result  (r_result),
        .i_mode    (r_mode),
        .o_match   (w_match),
        .o_new_sum (w_new_sum),
        .o_carry   (w_sum_carry)
    );

    assign w_next_term = {1'b0, r_a} + {1'b0, r_b};

    always_comb begin
        w_state_nxt      = r_state;
        w_a_nxt          = r_a;
        w_b_nxt          = r_b;
        w_term_carry_nxt = r_term_carry;
        w_limit_nxt      = r_limit;
        w_mode_nxt       = r_mode;
        w_result_nxt     = r_result;
        w_count_nxt      = r_count;
        w_overflow_nxt   = r_overflow;

        unique case (r_state)
            IDLE, DONE: begin
                if (bus.start) begin
                    w_limit_nxt      = bus.limit;
                    w_mode_nxt       = bus.mode;
                    w_a_nxt          = bus.seed0;
                    w_b_nxt          = bus.seed1;
                    w_term_carry_nxt = 1'b0;
                    w_result_nxt     = '0;
                    w_count_nxt      = '0;
                    w_overflow_nxt   = 1'b0;
                    w_state_nxt      = RUN;
                end
            end
            RUN: begin
                if (r_a == '0 && r_b == '0) begin
                    w_state_nxt = DONE;
                end else if (r_term_carry || r_b > r_limit) begin
                    // a carried-out term is unrepresentable, hence beyond any limit
                    w_state_nxt = DONE;
                end else if (w_match && w_sum_carry) begin
                    w_overflow_nxt = 1'b1;
                    w_state_nxt    = DONE;
                end else begin
                    if (w_match) begin
                        w_result_nxt = w_new_sum;
                        if (r_count != '1) begin
                            w_count_nxt = r_count + 1'b1;
                        end
                    end
                    w_a_nxt          = r_b;
                    w_b_nxt          = w_next_term[WIDTH-1:0];
                    w_term_carry_nxt = w_next_term[WIDTH];
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        w_busy_nxt = (w_state_nxt == RUN);
        w_done_nxt = (w_state_nxt == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_a          <= '0;
            r_b          <= '0;
            r_term_carry <= 1'b0;
            r_limit      <= '0;
            r_mode       <= MODE_ALL;
            r_result     <= '0;
            r_count      <= '0;
            r_overflow   <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_a          <= w_a_nxt;
            r_b          <= w_b_nxt;
            r_term_carry <= w_term_carry_nxt;
            r_limit      <= w_limit_nxt;
            r_mode       <= w_mode_nxt;
            r_result     <= w_result_nxt;
            r_count      <= w_count_nxt;
            r_overflow   <= w_overflow_nxt;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
        end
    end

    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.result   = r_result;
    assign bus.count    = r_count;
    assign bus.overflow = r_overflow;

endmodule
